run_stim_gen: RTL and testbench

- Stimulus generator that drives the run-detect datapath (threshold capture, then sample stream).
- Emits a threshold-capture command, then a programmable pattern: gap samples at or below threshold alternating with run samples above threshold.
- Tracks how many runs of length ≥4 it emitted (exp_cnt), so the bench can compare against the detector's N_abv count.
- Sits upstream of the detector as the source of sig / strtCapCmp.

---
 rtl/run_stim_gen.sv | 209 ++++++++++++++++++++
 tb/tb_run_stim_gen.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/run_stim_gen.sv
// run_stim_gen: threshold-capture command followed by gap/run sample pairs.
// Define RUN_STIM_NOISE_EN to add LFSR noise to gap/run samples.
module run_stim_gen #(
   parameter int W    = 8,
   parameter int CNTW = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            go,
   input  logic [W-1:0]    thresh,
   input  logic [3:0]      run_len,
   input  logic [3:0]      gap_len,
   input  logic [CNTW-1:0] n_runs,
   input  logic            sig_rdy,
   output logic [W-1:0]    sig,
   output logic            sig_vld,
   output logic            strt_cap_cmp,
   output logic            busy,
   output logic            done,
   output logic [CNTW-1:0] exp_cnt
);

   typedef enum logic [2:0] {IDLE, CAP, GAP, RUN, FIN} state_t;

   localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);

   state_t          state;
   state_t          after_pair;
   state_t          after_cap;
   logic [W-1:0]    thr_q;
   logic [3:0]      run_q;
   logic [3:0]      gap_q;
   logic [3:0]      idx;
   logic [3:0]      idx_nxt;
   logic [CNTW-1:0] nrun_q;
   logic [CNTW-1:0] pair_cnt;
   logic [CNTW-1:0] pair_nxt;
   logic            xfer;
   logic            pair_last;
   logic            gap_end;
   logic            run_end;
   logic            exp_ok;
   logic [1:0]      nz;
   logic [W-1:0]    gap0;
   logic [W-1:0]    gapn;
   logic [W-1:0]    run0;
   logic [W-1:0]    runn;
   logic [W-1:0]    seg0;

   // W+1 bit arithmetic: the top bit flags under/overflow for saturation
   function automatic logic [W-1:0] gap_smp(
      input logic [W-1:0] t,
      input logic [3:0]   k,
      input logic [1:0]   n
   );
      logic [W:0] v;
      v = {1'b0, t} - (W+1)'(k) - (W+1)'(n) - (W+1)'(1);
      return v[W] ? '0 : v[W-1:0];
   endfunction

   function automatic logic [W-1:0] run_smp(
      input logic [W-1:0] t,
      input logic [3:0]   k,
      input logic [1:0]   n
   );
      logic [W:0] v;
      v = {1'b0, t} + (W+1)'(k) + (W+1)'(n) + (W+1)'(1);
      return v[W] ? '1 : v[W-1:0];
   endfunction

   assign xfer      = sig_vld & sig_rdy;
   assign idx_nxt   = idx + 4'd1;
   assign gap_end   = (idx_nxt == gap_q);
   assign run_end   = (idx_nxt == run_q);
   assign pair_nxt  = pair_cnt + CNT_ONE;
   assign pair_last = (pair_nxt == nrun_q);
   assign exp_ok    = (run_q >= 4'd4) && (thr_q != '1);

   assign gap0 = gap_smp(thr_q, 4'd0, nz);
   assign gapn = gap_smp(thr_q, idx_nxt, nz);
   assign run0 = run_smp(thr_q, 4'd0, nz);
   assign runn = run_smp(thr_q, idx_nxt, nz);
   assign seg0 = (gap_q != 4'd0) ? gap0 : run0;

   assign after_pair = pair_last ? FIN
                     : (gap_q != 4'd0) ? GAP : RUN;
   assign after_cap  = ((nrun_q == '0) || (gap_q == 4'd0 && run_q == 4'd0)) ? FIN
                     : (gap_q != 4'd0) ? GAP : RUN;

`ifdef RUN_STIM_NOISE_EN
   logic [15:0] lfsr;
   logic [15:0] lfsr_nxt;

   assign lfsr_nxt = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
   assign nz       = lfsr_nxt[1:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lfsr <= 16'hACE1;
      end else if (xfer) begin
         lfsr <= lfsr_nxt;
      end
   end
`else
   assign nz = 2'b00;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         sig          <= '0;
         sig_vld      <= 1'b0;
         strt_cap_cmp <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
         exp_cnt      <= '0;
         thr_q        <= '0;
         run_q        <= '0;
         gap_q        <= '0;
         nrun_q       <= '0;
         pair_cnt     <= '0;
         idx          <= '0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (go) begin
                  thr_q        <= thresh;
                  run_q        <= run_len;
                  gap_q        <= gap_len;
                  nrun_q       <= n_runs;
                  exp_cnt      <= '0;
                  pair_cnt     <= '0;
                  idx          <= '0;
                  sig          <= thresh;
                  sig_vld      <= 1'b1;
                  strt_cap_cmp <= 1'b1;
                  busy         <= 1'b1;
                  state        <= CAP;
               end
            end
            CAP: begin
               if (xfer) begin
                  strt_cap_cmp <= 1'b0;
                  idx          <= '0;
                  state        <= after_cap;
                  if (after_cap == FIN) begin
                     sig_vld <= 1'b0;
                     done    <= 1'b1;
                  end else begin
                     sig <= seg0;
                  end
               end
            end
            GAP: begin
               if (xfer) begin
                  if (!gap_end) begin
                     idx <= idx_nxt;
                     sig <= gapn;
                  end else if (run_q != 4'd0) begin
                     idx   <= '0;
                     sig   <= run0;
                     state <= RUN;
                  end else begin
                     pair_cnt <= pair_nxt;
                     idx      <= '0;
                     state    <= after_pair;
                     if (pair_last) begin
                        sig_vld <= 1'b0;
                        done    <= 1'b1;
                     end else begin
                        sig <= seg0;
                     end
                  end
               end
            end
            RUN: begin
               if (xfer) begin
                  if (!run_end) begin
                     idx <= idx_nxt;
                     sig <= runn;
                  end else begin
                     pair_cnt <= pair_nxt;
                     idx      <= '0;
                     state    <= after_pair;
                     if (exp_ok) begin
                        exp_cnt <= exp_cnt + CNT_ONE;
                     end
                     if (pair_last) begin
                        sig_vld <= 1'b0;
                        done    <= 1'b1;
                     end else begin
                        sig <= seg0;
                     end
                  end
               end
            end
            FIN: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_run_stim_gen.sv
// tb_run_stim_gen: randomized stimulus against a list-based model of the
// expected sample stream and long-run count.
module tb_run_stim_gen;

   localparam int W    = 8;
   localparam int CNTW = 8;
   localparam int SMAX = (1 << W) - 1;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            go = 1'b0;
   logic [W-1:0]    thresh = '0;
   logic [3:0]      run_len = '0;
   logic [3:0]      gap_len = '0;
   logic [CNTW-1:0] n_runs = '0;
   logic            sig_rdy = 1'b0;
   logic [W-1:0]    sig;
   logic            sig_vld;
   logic            strt_cap_cmp;
   logic            busy;
   logic            done;
   logic [CNTW-1:0] exp_cnt;

   int total = 0;
   int bad = 0;
   int exp_q[$];
   int exp_runs;

   run_stim_gen #(.W(W), .CNTW(CNTW)) dut (
      .clk(clk),
      .rst(rst),
      .go(go),
      .thresh(thresh),
      .run_len(run_len),
      .gap_len(gap_len),
      .n_runs(n_runs),
      .sig_rdy(sig_rdy),
      .sig(sig),
      .sig_vld(sig_vld),
      .strt_cap_cmp(strt_cap_cmp),
      .busy(busy),
      .done(done),
      .exp_cnt(exp_cnt)
   );

   always #5 clk = ~clk;

   // Expected transfer list: threshold, then per pair the gap and run samples.
   function automatic void build_model(int thr, int rl, int gl, int nr);
      exp_q.delete();
      exp_runs = 0;
      exp_q.push_back(thr);
      if (nr == 0 || (gl == 0 && rl == 0)) return;
      for (int p = 0; p < nr; p++) begin
         for (int k = 0; k < gl; k++)
            exp_q.push_back((thr - 1 - k < 0) ? 0 : thr - 1 - k);
         for (int k = 0; k < rl; k++)
            exp_q.push_back((thr + 1 + k > SMAX) ? SMAX : thr + 1 + k);
         if (rl >= 4 && thr != SMAX) exp_runs++;
      end
   endfunction

   // mode 0: rdy always 1, mode 1: rdy toggles, mode 2: rdy random
   task automatic run_seq(input string nm, input int thr, input int rl,
                          input int gl, input int nr, input int mode);
      int n;
      int cyc;
      int lim;
      logic rdy;
      logic held;
      logic fin;
      logic [W-1:0] hold_sig;
      logic hold_cap;
      build_model(thr, rl, gl, nr);
      thresh  = W'(thr);
      run_len = 4'(rl);
      gap_len = 4'(gl);
      n_runs  = CNTW'(nr);
      go      = 1'b1;
      sig_rdy = 1'b0;
      @(posedge clk); #1;
      go = 1'b0;
      total++;
      if (busy !== 1'b1 || sig_vld !== 1'b1 || strt_cap_cmp !== 1'b1) begin
         bad++;
         $display("FAIL %s start: busy/vld/cap=%b%b%b required 111",
                  nm, busy, sig_vld, strt_cap_cmp);
      end
      n = 0;
      cyc = 0;
      held = 1'b0;
      fin = 1'b0;
      hold_sig = '0;
      hold_cap = 1'b0;
      lim = 4 * exp_q.size() + 20;
      while (!fin && cyc < lim) begin
         if (held) begin
            total++;
            if (sig_vld !== 1'b1 || sig !== hold_sig || strt_cap_cmp !== hold_cap) begin
               bad++;
               $display("FAIL %s stall: vld=%b sig=%h cap=%b required 1 %h %b",
                        nm, sig_vld, sig, strt_cap_cmp, hold_sig, hold_cap);
            end
         end
         if (done === 1'b1) begin
            fin = 1'b1;
         end else begin
            total++;
            if (sig_vld !== 1'b1) begin
               bad++;
               $display("FAIL %s vld: got %b required 1 at cycle %0d", nm, sig_vld, cyc);
            end
            if (mode == 0) rdy = 1'b1;
            else if (mode == 1) rdy = (cyc % 2 == 0);
            else rdy = ($urandom_range(0, 3) != 0);
            sig_rdy = rdy;
            thresh  = W'($urandom);
            run_len = 4'($urandom);
            gap_len = 4'($urandom);
            n_runs  = CNTW'($urandom);
            go      = 1'($urandom_range(0, 1));
            held     = sig_vld && !rdy;
            hold_sig = sig;
            hold_cap = strt_cap_cmp;
            if (sig_vld && rdy) begin
               total++;
               if (n >= exp_q.size() || sig !== W'(exp_q[n]) ||
                   strt_cap_cmp !== (n == 0)) begin
                  bad++;
                  $display("FAIL %s sample %0d: sig=%h cap=%b required %h %b",
                           nm, n, sig, strt_cap_cmp,
                           (n < exp_q.size()) ? exp_q[n] : -1, (n == 0));
               end
               n++;
            end
            @(posedge clk); #1;
            cyc++;
         end
      end
      go = 1'b0;
      sig_rdy = 1'b0;
      total++;
      if (!fin) begin
         bad++;
         $display("FAIL %s timeout: no done after %0d cycles", nm, cyc);
      end else begin
         total++;
         if (n != exp_q.size()) begin
            bad++;
            $display("FAIL %s count: %0d transfers required %0d", nm, n, exp_q.size());
         end
         total++;
         if (exp_cnt !== CNTW'(exp_runs)) begin
            bad++;
            $display("FAIL %s exp_cnt: got %0d required %0d", nm, exp_cnt, exp_runs);
         end
         if (mode == 0) begin
            total++;
            if (cyc != exp_q.size()) begin
               bad++;
               $display("FAIL %s latency: done after %0d required %0d", nm, cyc, exp_q.size());
            end
         end
         total++;
         if (sig_vld !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL %s fin: vld=%b busy=%b required 0 1", nm, sig_vld, busy);
         end
         @(posedge clk); #1;
         total++;
         if (done !== 1'b0 || busy !== 1'b0 || exp_cnt !== CNTW'(exp_runs)) begin
            bad++;
            $display("FAIL %s idle: done=%b busy=%b exp=%0d required 0 0 %0d",
                     nm, done, busy, exp_cnt, exp_runs);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      total++;
      if (sig !== '0 || sig_vld !== 1'b0 || strt_cap_cmp !== 1'b0 ||
          busy !== 1'b0 || done !== 1'b0 || exp_cnt !== '0) begin
         bad++;
         $display("FAIL reset: sig=%h vld=%b cap=%b busy=%b done=%b exp=%0d required all 0",
                  sig, sig_vld, strt_cap_cmp, busy, done, exp_cnt);
      end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      run_seq("basic", 8'h40, 4, 2, 3, 0);
      run_seq("short_runs", 8'h40, 3, 1, 2, 0);
   endtask

   task automatic test_saturate();
      run_seq("gap_sat", 8'h01, 1, 3, 1, 0);
      run_seq("run_sat", 8'hFE, 4, 1, 2, 0);
      run_seq("thr_max", 8'hFF, 4, 1, 2, 0);
   endtask

   task automatic test_stall();
      run_seq("stall", 8'h40, 4, 2, 2, 1);
   endtask

   task automatic test_edges();
      run_seq("zero_pairs", 8'h40, 4, 2, 0, 0);
      run_seq("no_gap", 8'h40, 5, 0, 2, 0);
      run_seq("empty_pairs", 8'h20, 0, 0, 3, 0);
      run_seq("gap_only", 8'h20, 0, 2, 2, 0);
   endtask

   task automatic test_random();
      for (int i = 0; i < 10; i++)
         run_seq("random", int'($urandom_range(0, SMAX)), int'($urandom_range(0, 15)),
                 int'($urandom_range(0, 15)), int'($urandom_range(0, 5)), 2);
   endtask

   task automatic test_reset_mid();
      thresh  = 8'h40;
      run_len = 4'd4;
      gap_len = 4'd2;
      n_runs  = 8'd3;
      go      = 1'b1;
      @(posedge clk); #1;
      go = 1'b0;
      sig_rdy = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      total++;
      if (sig !== 8'h43 || sig_vld !== 1'b1) begin
         bad++;
         $display("FAIL mid_pre: sig=%h vld=%b required 43 1", sig, sig_vld);
      end
      rst = 1'b1;
      #1;
      total++;
      if (sig !== '0 || sig_vld !== 1'b0 || strt_cap_cmp !== 1'b0 ||
          busy !== 1'b0 || done !== 1'b0 || exp_cnt !== '0) begin
         bad++;
         $display("FAIL mid_rst: sig=%h vld=%b cap=%b busy=%b done=%b exp=%0d required all 0",
                  sig, sig_vld, strt_cap_cmp, busy, done, exp_cnt);
      end
      sig_rdy = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
         total++;
         if (done !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL mid_hold: done=%b busy=%b required 0 0", done, busy);
         end
      end
      rst = 1'b0;
      @(posedge clk); #1;
      run_seq("after_rst", 8'h40, 4, 2, 3, 0);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_saturate();
      test_stall();
      test_edges();
      test_random();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
